// File: rtl/rr_arbiter8_dec_if.sv
// Request/grant bundle between the round-robin arbiter and its requesters.
interface rr_arbiter8_dec_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Requester side: drives enable, requests and done; observes the grant.
    modport master (
        output en,
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8_dec.sv
// Eight-way round-robin arbiter with a decoded one-hot grant. An owner keeps the
// grant until done, request drop, enable loss or the hold timeout, and every
// hand-over passes through at least one idle cycle.
module rr_arbiter8_dec #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter8_dec_if.slave arb_io
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam bit                TimeoutEn = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HoldLast  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HoldMax   = '1;

    logic [0:0]        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [7:0]        grant_q, grant_d;
    logic              timeout_q, timeout_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       release_now;

    // Rotating priority search: first set request starting at ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && arb_io.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // FSM next state, hold counter and release decision.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        release_now = 1'b0;

        if (state_q == StIdle) begin
            valid_d = 1'b0;
            if (arb_io.en && win_found) begin
                state_d = StBusy;
                idx_d   = win_idx;
                valid_d = 1'b1;
                hold_d  = '0;
            end
        end else begin
            // Priority: enable loss, done, request drop, then timeout.
            // done on the timeout cycle therefore suppresses the timeout pulse.
            if (!arb_io.en || arb_io.done || !arb_io.req[idx_q]) begin
                release_now = 1'b1;
            end else if (TimeoutEn && (hold_q == HoldLast)) begin
                release_now = 1'b1;
                timeout_d   = 1'b1;
            end

            if (release_now) begin
                state_d = StIdle;
                valid_d = 1'b0;
                ptr_d   = idx_q + 3'd1;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // 3-to-8 decode of the next owner, gated by the next valid.
    always_comb begin
        grant_d = '0;
        if (valid_d) begin
            grant_d[idx_d] = 1'b1;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb_io.grant       = grant_q;
    assign arb_io.grant_idx   = idx_q;
    assign arb_io.grant_valid = valid_q;
    assign arb_io.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8_dec.sv
// Directed bench for rr_arbiter8_dec: stimulus pushes expected grants/timeouts into
// queues, a negedge monitor pops them as the arbiter presents new grants.
module tb_rr_arbiter8_dec;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_arbiter8_dec_if bus ();

    rr_arbiter8_dec #(
        .MAX_HOLD (15),
        .HOLD_W   (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_io (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   exp_grant_q[$];
    int   exp_to_q[$];
    logic prev_gv = 1'b0;
    logic [7:0] mon_dec;
    int   mon_exp;
    int   t2_seq[4] = '{2, 5, 7, 2};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop an expectation on every new grant and every timeout pulse.
    always @(negedge clk) begin
        if (bus.grant_valid === 1'b1 && prev_gv !== 1'b1) begin
            if (exp_grant_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant got_idx=%0d exp=none", bus.grant_idx);
            end else begin
                mon_exp = exp_grant_q.pop_front();
                mon_dec = 8'd1 << mon_exp;
                chk("mon_grant_idx", 32'(bus.grant_idx), 32'(mon_exp));
                chk("mon_grant_onehot", 32'(bus.grant), 32'(mon_dec));
            end
        end
        if (bus.timeout === 1'b1) begin
            if (exp_to_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_timeout got=1 exp=0");
            end else begin
                mon_exp = exp_to_q.pop_front();
                chk("mon_timeout_gv_low", 32'(bus.grant_valid), 32'd0);
            end
        end
        mon_dec = 8'h00;
        if (bus.grant_valid === 1'b1) mon_dec = 8'd1 << bus.grant_idx;
        chk("mon_grant_consistent", 32'(bus.grant), 32'(mon_dec));
        prev_gv = bus.grant_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // T1: reset with all requests pending.
        bus.en   = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        tick;
        tick;
        chk("t1_rst_grant", 32'(bus.grant), 32'h0);
        chk("t1_rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("t1_rst_timeout", 32'(bus.timeout), 32'd0);
        chk("t1_rst_idx", 32'(bus.grant_idx), 32'd0);
        rst_n = 1'b1;
        exp_grant_q.push_back(0);
        tick;
        chk("t1_first_valid", 32'(bus.grant_valid), 32'd1);
        chk("t1_first_idx", 32'(bus.grant_idx), 32'd0);
        bus.done = 1'b1;
        bus.req  = 8'b1010_0100;
        tick;
        bus.done = 1'b0;
        chk("t1_release", 32'(bus.grant_valid), 32'd0);

        // T2: round-robin over 2,5,7 with done one cycle into each grant.
        for (int k = 0; k < 4; k++) begin
            exp_grant_q.push_back(t2_seq[k]);
            tick;
            chk("t2_valid", 32'(bus.grant_valid), 32'd1);
            chk("t2_idx", 32'(bus.grant_idx), 32'(t2_seq[k]));
            bus.done = 1'b1;
            tick;
            bus.done = 1'b0;
            chk("t2_gap", 32'(bus.grant_valid), 32'd0);
        end
        bus.req = 8'h00;

        // T3: owner 6 releases so the pointer sits at 7, then wrap to 0 and 1.
        bus.req = 8'h40;
        exp_grant_q.push_back(6);
        tick;
        chk("t3_idx6", 32'(bus.grant_idx), 32'd6);
        bus.done = 1'b1;
        bus.req  = 8'h03;
        tick;
        bus.done = 1'b0;
        chk("t3_rel6", 32'(bus.grant_valid), 32'd0);
        exp_grant_q.push_back(0);
        tick;
        chk("t3_wrap_idx0", 32'(bus.grant_idx), 32'd0);
        bus.done = 1'b1;
        tick;
        bus.done = 1'b0;
        chk("t3_rel0", 32'(bus.grant_valid), 32'd0);
        exp_grant_q.push_back(1);
        tick;
        chk("t3_idx1", 32'(bus.grant_idx), 32'd1);
        bus.req = 8'h00;
        tick;
        chk("t3_req_drop", 32'(bus.grant_valid), 32'd0);

        // T4: owner 3 held with no done until the hold timeout.
        bus.req = 8'h08;
        exp_grant_q.push_back(3);
        tick;
        chk("t4_grant", 32'(bus.grant), 32'h08);
        for (int c = 2; c <= 15; c++) begin
            tick;
            chk("t4_hold_valid", 32'(bus.grant_valid), 32'd1);
            chk("t4_hold_no_to", 32'(bus.timeout), 32'd0);
        end
        exp_to_q.push_back(3);
        tick;
        chk("t4_to_release", 32'(bus.grant_valid), 32'd0);
        chk("t4_to_pulse", 32'(bus.timeout), 32'd1);
        exp_grant_q.push_back(3);
        tick;
        chk("t4_regrant", 32'(bus.grant_valid), 32'd1);
        chk("t4_regrant_idx", 32'(bus.grant_idx), 32'd3);
        chk("t4_to_cleared", 32'(bus.timeout), 32'd0);

        // T5: done lands on the timeout cycle; done wins, no timeout pulse.
        for (int c = 2; c <= 15; c++) begin
            tick;
            chk("t5_hold_valid", 32'(bus.grant_valid), 32'd1);
        end
        bus.done = 1'b1;
        tick;
        bus.done = 1'b0;
        bus.req  = 8'h00;
        chk("t5_release", 32'(bus.grant_valid), 32'd0);
        chk("t5_no_timeout", 32'(bus.timeout), 32'd0);

        // T6: enable drop mid-grant advances the pointer; reset mid-grant clears it.
        bus.req = 8'h30;
        exp_grant_q.push_back(4);
        tick;
        chk("t6_idx4", 32'(bus.grant_idx), 32'd4);
        tick;
        chk("t6_busy", 32'(bus.grant_valid), 32'd1);
        bus.en = 1'b0;
        tick;
        chk("t6_en_release", 32'(bus.grant_valid), 32'd0);
        chk("t6_en_grant0", 32'(bus.grant), 32'h0);
        bus.en = 1'b1;
        exp_grant_q.push_back(5);
        tick;
        chk("t6_ptr_advanced", 32'(bus.grant_idx), 32'd5);
        bus.req = 8'h21;
        tick;
        chk("t6_still_5", 32'(bus.grant_valid), 32'd1);
        rst_n = 1'b0;
        tick;
        chk("t6_rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("t6_rst_grant", 32'(bus.grant), 32'h0);
        chk("t6_rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;
        exp_grant_q.push_back(0);
        tick;
        chk("t6_ptr_reset", 32'(bus.grant_idx), 32'd0);

        // Enable low in idle blocks new grants.
        bus.done = 1'b1;
        tick;
        bus.done = 1'b0;
        bus.en   = 1'b0;
        chk("en_low_rel", 32'(bus.grant_valid), 32'd0);
        tick;
        tick;
        chk("en_low_idle", 32'(bus.grant_valid), 32'd0);
        bus.en  = 1'b1;
        bus.req = 8'h00;
        tick;
        tick;
        chk("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
        chk("to_q_empty", 32'(exp_to_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
